// File: rtl/ternary_pkg.sv
// Shared trit encoding, default sizes and legality helpers for the ternary memory family.
package ternary_pkg;

    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;

    localparam int WORD_SIZE_DEF     = 9;
    localparam int MEM_ADDR_SIZE_DEF = 3;
    // Widest word the legality helper accepts; callers zero-pad narrower words.
    localparam int MAX_TRITS         = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic trit_is_legal(input logic [1:0] trit);
        return (trit == T_NEG) || (trit == T_ZERO) || (trit == T_POS);
    endfunction

    function automatic logic word_is_legal(input logic [2*MAX_TRITS-1:0] word);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_TRITS; i++) begin
            if (!trit_is_legal(word[2*i +: 2])) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int trit_value(input logic [1:0] trit);
        int v;
        v = 0;
        if (trit == T_POS) v = 1;
        else if (trit == T_NEG) v = -1;
        return v;
    endfunction

endpackage

// File: rtl/ternary_addr_decode.sv
// Balanced-ternary address to linear word index, with a flag for illegal trit encodings.
module ternary_addr_decode
    import ternary_pkg::*;
#(
    parameter  int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF,
    localparam int MEM_SIZE      = 3**MEM_ADDR_SIZE,
    localparam int IDX_W         = $clog2(MEM_SIZE)
) (
    input  logic [2*MEM_ADDR_SIZE-1:0] address,
    output logic [IDX_W-1:0]           index,
    output logic                       legal
);

    int acc;
    int weight;

    // Offset by half the range so the all-negative address lands on index 0.
    always_comb begin
        acc    = (MEM_SIZE - 1) / 2;
        weight = 1;
        legal  = 1'b1;
        for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
            if (!trit_is_legal(address[2*i +: 2])) legal = 1'b0;
            acc    = acc + trit_value(address[2*i +: 2]) * weight;
            weight = weight * 3;
        end
        index = IDX_W'(acc);
    end

endmodule

// File: rtl/ternary_memory_dp.sv
// Dual-port ternary data memory with a sequential post-reset clear and sticky illegal-trit flag.
//   state | meaning
//   CLEAR | wiping mem[clear_ptr] each cycle, requests ignored, busy high
//   READY | serving read and write ports
module ternary_memory_dp
    import ternary_pkg::*;
#(
    parameter  int WORD_SIZE     = WORD_SIZE_DEF,
    parameter  int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF,
    localparam int MEM_SIZE      = 3**MEM_ADDR_SIZE,
    localparam int IDX_W         = $clog2(MEM_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [2*MEM_ADDR_SIZE-1:0] write_address,
    input  logic [2*WORD_SIZE-1:0]     write_data,
    input  logic                       read_enable,
    input  logic [2*MEM_ADDR_SIZE-1:0] read_address,
    output logic [2*WORD_SIZE-1:0]     read_data,
    output logic                       read_valid,
    output logic                       busy,
    output logic                       error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

    state_t                 state, state_next;
    logic [IDX_W-1:0]       clear_ptr, clear_ptr_next;
    logic                   clear_we;
    logic [2*WORD_SIZE-1:0] mem [MEM_SIZE];

    logic [IDX_W-1:0]       wr_index, rd_index;
    logic                   wr_addr_legal, rd_addr_legal, wr_data_legal;
    logic [2*MAX_TRITS-1:0] write_data_ext;
    logic                   ready, wr_ok, rd_ok, bad_request;

    ternary_addr_decode #(.MEM_ADDR_SIZE(MEM_ADDR_SIZE)) u_wr_decode (
        .address (write_address),
        .index   (wr_index),
        .legal   (wr_addr_legal)
    );

    ternary_addr_decode #(.MEM_ADDR_SIZE(MEM_ADDR_SIZE)) u_rd_decode (
        .address (read_address),
        .index   (rd_index),
        .legal   (rd_addr_legal)
    );

    always_comb begin
        write_data_ext                  = '0;
        write_data_ext[2*WORD_SIZE-1:0] = write_data;
    end

    assign wr_data_legal = word_is_legal(write_data_ext);
    assign ready         = (state == READY);
    assign wr_ok         = ready && write_enable && wr_addr_legal && wr_data_legal;
    assign rd_ok         = ready && read_enable && rd_addr_legal;
    assign bad_request   = ready && ((write_enable && !(wr_addr_legal && wr_data_legal)) ||
                                     (read_enable && !rd_addr_legal));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_next;
            clear_ptr <= clear_ptr_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_ptr_next = clear_ptr;
        clear_we       = 1'b0;
        busy           = 1'b0;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                if (clear_ptr == LAST_IDX) begin
                    state_next     = READY;
                    clear_ptr_next = '0;
                end else begin
                    clear_ptr_next = clear_ptr + IDX_W'(1);
                end
            end
            READY:   ;
            default: state_next = CLEAR;
        endcase
    end

    // A reset edge only restarts the sweep; it does not write the array itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clear_we) mem[clear_ptr] <= '0;
            else if (wr_ok) mem[wr_index] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            read_valid <= rd_ok;
            if (rd_ok) begin
                read_data <= (wr_ok && (wr_index == rd_index)) ? write_data : mem[rd_index];
            end
            if (bad_request) error <= 1'b1;
        end
    end

endmodule
